// File: rtl/lsu_mem_if.sv
// Load/store unit between execute and a single-cycle data RAM: one request at a time,
// legality check, one RAM access cycle, registered response. Optional counters: LSU_PERF_CNT_EN.
module lsu_mem_if #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
`ifdef LSU_PERF_CNT_EN
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_errs,
`endif
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never waits on ready, and payload stays stable while valid is high and ready is low.

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e      state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rdata_q;
  logic        mem_we_q;

  logic        req_err;
  logic        f3_legal;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Request legality, evaluated on the live request inputs at accept time.
  always_comb begin
    f3_legal = (req_funct3 == F3_B)  || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
               (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
    req_err  = 1'b0;
    if (!f3_legal)
      req_err = 1'b1;
    if (req_we && ((req_funct3 == F3_BU) || (req_funct3 == F3_HU)))
      req_err = 1'b1;
    if (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0])
      req_err = 1'b1;
    if ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00))
      req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= MEM_WORDS)
      req_err = 1'b1;
  end

  always_comb begin
    ld_byte = 8'h00;
    case (addr_q[1:0])
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data = 32'h0;
    case (funct3_q)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'h0, ld_half};
      F3_W:    ld_data = mem_rdata;
      default: ld_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= 32'h0;
      mem_we_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            we_q        <= req_we;
            funct3_q    <= req_funct3;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            rdata_q     <= 32'h0;
            if (req_err) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q  <= S_ACCESS;
              mem_we_q <= req_we;
            end
          end
        end
        S_ACCESS: begin
          // The RAM read word is combinational on mem_addr, so it is valid this cycle.
          mem_we_q    <= 1'b0;
          rdata_q     <= we_q ? 32'h0 : ld_data;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= 32'h0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          mem_we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rdata_q;
  assign mem_we     = mem_we_q;
  assign mem_funct3 = funct3_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign dbg_state  = state_q;

`ifdef LSU_PERF_CNT_EN
  logic [31:0] perf_loads_q;
  logic [31:0] perf_stores_q;
  logic [31:0] perf_errs_q;

  // Counted at the response handshake so a reset mid-transaction counts nothing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_loads_q  <= 32'h0;
      perf_stores_q <= 32'h0;
      perf_errs_q   <= 32'h0;
    end else if (rsp_valid_q && rsp_ready) begin
      if (rsp_err_q)
        perf_errs_q <= perf_errs_q + 32'd1;
      else if (we_q)
        perf_stores_q <= perf_stores_q + 32'd1;
      else
        perf_loads_q <= perf_loads_q + 32'd1;
    end
  end

  assign perf_loads  = perf_loads_q;
  assign perf_stores = perf_stores_q;
  assign perf_errs   = perf_errs_q;
`endif

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: byte-addressed RAM model, transaction-level reference memory,
// directed plan steps followed by randomized traffic. Honours LSU_PERF_CNT_EN.
module tb_lsu_mem_if;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] perf_loads;
  logic [31:0] perf_stores;
  logic [31:0] perf_errs;
`endif

  lsu_mem_if #(.MEM_WORDS(256)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_funct3 (mem_funct3),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
`ifdef LSU_PERF_CNT_EN
    .perf_loads (perf_loads),
    .perf_stores(perf_stores),
    .perf_errs  (perf_errs),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM attached to the DUT ----------------
  logic [7:0]  ram_b    [0:1023];
  logic [7:0]  init_img [0:1023];
  logic        ram_init;
  logic [7:0]  wa;
  logic [9:0]  ba;

  assign wa = mem_addr[9:2];
  assign ba = mem_addr[9:0];
  assign mem_rdata = {ram_b[{wa, 2'd3}], ram_b[{wa, 2'd2}], ram_b[{wa, 2'd1}], ram_b[{wa, 2'd0}]};

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram_b[i] <= init_img[i];
    end else if (mem_we) begin
      case (mem_funct3[1:0])
        2'b00: ram_b[ba] <= mem_wdata[7:0];
        2'b01: begin
          ram_b[{ba[9:1], 1'b0}] <= mem_wdata[7:0];
          ram_b[{ba[9:1], 1'b1}] <= mem_wdata[15:8];
        end
        default: begin
          ram_b[{wa, 2'd0}] <= mem_wdata[7:0];
          ram_b[{wa, 2'd1}] <= mem_wdata[15:8];
          ram_b[{wa, 2'd2}] <= mem_wdata[23:16];
          ram_b[{wa, 2'd3}] <= mem_wdata[31:24];
        end
      endcase
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:255];
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          n_total;
  int          n_pass;
  int          m_loads, m_stores, m_errs;

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int f = int'(f3);
    if (!(f == 0 || f == 1 || f == 2 || f == 4 || f == 5)) return 1'b1;
    if (we && f >= 4) return 1'b1;
    if ((f == 1 || f == 5) && (a % 2) != 0) return 1'b1;
    if (f == 2 && (a % 4) != 0) return 1'b1;
    if ((a / 4) >= 256) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w = ref_mem[(a / 4) % 256];
    logic [31:0] off = a % 4;
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        v = (w >> (8 * off)) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        v = (w >> (8 * off)) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off = a % 4;
    logic [31:0] mask;
    int idx = int'(a / 4);
    case (f3)
      3'b000:  mask = 32'hFF << (8 * off);
      3'b001:  mask = 32'hFFFF << (8 * off);
      default: mask = 32'hFFFF_FFFF;
    endcase
    ref_mem[idx] = (ref_mem[idx] & ~mask) | ((d << (8 * off)) & mask);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_perf();
`ifdef LSU_PERF_CNT_EN
    chk("perf_loads", perf_loads, 32'(m_loads));
    chk("perf_stores", perf_stores, 32'(m_stores));
    chk("perf_errs", perf_errs, 32'(m_errs));
`endif
  endtask

  // ---------------- driver: one full request/response transaction ----------------
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int bp,
                        output logic [31:0] got_d, output logic got_e);
    logic        e;
    logic [31:0] ed;
    int          cyc;
    int          we_cnt;
    e  = model_err(we, f3, addr);
    ed = (e || we) ? 32'h0 : model_load(f3, addr);
    exp_q.push_back(ed);
    exp_err_q.push_back(e);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    cyc = 1; we_cnt = 0;
    while (!rsp_valid && cyc < 8) begin
      if (mem_we) we_cnt++;
      if (cyc == 1) begin
        chk("mem_addr", mem_addr, addr);
        chk("mem_funct3", 32'(mem_funct3), 32'(f3));
        chk("mem_wdata", mem_wdata, wd);
        chk("req_ready_busy", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), e ? 32'd1 : 32'd2);
    chk("mem_we_pulses", 32'(we_cnt), 32'(we && !e));
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err_q.pop_front()));
    chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
    got_d = rsp_rdata;
    got_e = rsp_err;
    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = $urandom;
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata_stable", rsp_rdata, got_d);
      chk("bp_err_stable", 32'(rsp_err), 32'(got_e));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_mem_we", 32'(mem_we), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
    if (!e && we) model_store(f3, addr, wd);
    if (e) m_errs++;
    else if (we) m_stores++;
    else m_loads++;
    chk_perf();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic        er;
    logic [2:0]  f3;
    logic [31:0] a;
    logic        we;
    n_total = 0; n_pass = 0;
    m_loads = 0; m_stores = 0; m_errs = 0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      for (int k = 0; k < 4; k++) init_img[4 * i + k] = ref_mem[i][8 * k +: 8];
    end
    ram_init = 1'b1;
    reset_n  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk_perf();
    ram_init = 1'b0;
    reset_n  = 1'b1;

    do_txn(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, d, er);
    do_txn(1'b0, 3'b010, 32'h10, 32'h0, 0, d, er);
    chk("lw_deadbeef", d, 32'hDEAD_BEEF);
    do_txn(1'b1, 3'b010, 32'h10, 32'h80FF_7F01, 0, d, er);
    do_txn(1'b0, 3'b000, 32'h13, 32'h0, 0, d, er);
    chk("lb_13", d, 32'hFFFF_FF80);
    do_txn(1'b0, 3'b100, 32'h13, 32'h0, 0, d, er);
    chk("lbu_13", d, 32'h0000_0080);
    do_txn(1'b0, 3'b001, 32'h12, 32'h0, 0, d, er);
    chk("lh_12", d, 32'hFFFF_80FF);
    do_txn(1'b0, 3'b101, 32'h10, 32'h0, 0, d, er);
    chk("lhu_10", d, 32'h0000_7F01);
    do_txn(1'b0, 3'b010, 32'h12, 32'h0, 0, d, er);
    chk("lw_misaligned_err", 32'(er), 32'd1);
    do_txn(1'b1, 3'b001, 32'h11, 32'h5555_AAAA, 0, d, er);
    chk("sh_misaligned_err", 32'(er), 32'd1);
    do_txn(1'b0, 3'b010, 32'h400, 32'h0, 0, d, er);
    chk("lw_oor_err", 32'(er), 32'd1);
    do_txn(1'b0, 3'b011, 32'h10, 32'h0, 0, d, er);
    chk("f3_011_err", 32'(er), 32'd1);
    do_txn(1'b1, 3'b100, 32'h10, 32'h0000_00AA, 0, d, er);
    chk("sb_f3_100_err", 32'(er), 32'd1);
    do_txn(1'b0, 3'b010, 32'h10, 32'h0, 5, d, er);
    chk("lw_after_errs", d, 32'h80FF_7F01);

    // reset asserted while a store is in its RAM access cycle
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_access_we", 32'(mem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
    m_loads = 0; m_stores = 0; m_errs = 0;
    chk_perf();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    do_txn(1'b0, 3'b010, 32'h10, 32'h0, 0, d, er);
    chk("lw_after_reset", d, 32'h80FF_7F01);

    for (int n = 0; n < 80; n++) begin
      int r = $urandom_range(0, 11);
      case (r)
        0, 1:    f3 = 3'b000;
        2, 3:    f3 = 3'b001;
        4, 5:    f3 = 3'b010;
        6, 7:    f3 = 3'b100;
        8, 9:    f3 = 3'b101;
        10:      f3 = 3'b011;
        default: f3 = 3'($urandom_range(6, 7));
      endcase
      we = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) a = a & ~32'h1;
        if (f3[1:0] == 2'b10) a = a & ~32'h3;
      end
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 8)) * 32'h400;
      do_txn(we, f3, a, $urandom, $urandom_range(0, 3), d, er);
    end

    for (int i = 0; i < 256; i += 17) begin
      do_txn(1'b0, 3'b010, 32'(4 * i), 32'h0, 0, d, er);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
